// File: rtl/uart_fifo_tx_if.sv
// rtl/uart_fifo_tx_if.sv - fifo read port, baud tick and serial line bundle for uart_fifo_tx
interface uart_fifo_tx_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_rdata;
  logic            fifo_rd;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    input  s_tick,
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd,
    output tx,
    output tx_busy,
    output tx_done_tick
  );

  modport slave (
    output s_tick,
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - drains a FWFT fifo and serialises each word as a UART frame
module uart_fifo_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter bit PAR_EN  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_tx_if.master bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;

  // The pop strobe shares the edge that captures the head word, so it must be
  // decoded from the current state rather than registered.
  assign load        = (state_q == IDLE) && !bus.fifo_empty && !reset;
  assign bus.fifo_rd = load;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          b_d     = bus.fifo_rdata;
          par_d   = ^bus.fifo_rdata;
          s_d     = 5'd0;
          state_d = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == 5'd15) begin
            s_d     = 5'd0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == 5'd15) begin
            s_d = 5'd0;
            b_d = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
              state_d = PAR_EN ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (s_q == 5'd15) begin
            s_d     = 5'd0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            s_d     = 5'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= 5'd0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - directed bench: default, parity and 2-stop-bit transmitters fed by fifo models
module tb_uart_fifo_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  int   tcnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // One baud tick every 10 clks, changed on the falling edge.
  always @(negedge clk) begin
    tcnt   = (tcnt == 9) ? 0 : tcnt + 1;
    s_tick = (tcnt == 9);
  end

  uart_fifo_tx_if #(.DBIT(8)) if0 ();
  uart_fifo_tx_if #(.DBIT(8)) if1 ();
  uart_fifo_tx_if #(.DBIT(8)) if2 ();

  uart_fifo_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  uart_fifo_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  uart_fifo_tx #(.DBIT(8), .SB_TICK(32), .PAR_EN(1'b0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic       empty_w [3];
  logic [7:0] rdata_w [3];
  logic       rd_w [3];
  logic       tx_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  assign if0.s_tick = s_tick;  assign if0.fifo_empty = empty_w[0];  assign if0.fifo_rdata = rdata_w[0];
  assign if1.s_tick = s_tick;  assign if1.fifo_empty = empty_w[1];  assign if1.fifo_rdata = rdata_w[1];
  assign if2.s_tick = s_tick;  assign if2.fifo_empty = empty_w[2];  assign if2.fifo_rdata = rdata_w[2];
  assign rd_w[0] = if0.fifo_rd;  assign tx_w[0] = if0.tx;  assign busy_w[0] = if0.tx_busy;  assign done_w[0] = if0.tx_done_tick;
  assign rd_w[1] = if1.fifo_rd;  assign tx_w[1] = if1.tx;  assign busy_w[1] = if1.tx_busy;  assign done_w[1] = if1.tx_done_tick;
  assign rd_w[2] = if2.fifo_rd;  assign tx_w[2] = if2.tx;  assign busy_w[2] = if2.tx_busy;  assign done_w[2] = if2.tx_done_tick;

  logic [7:0] mem [3][16];
  int         wp [3] = '{0, 0, 0};
  int         rp [3] = '{0, 0, 0};
  logic       pop [3] = '{1'b0, 1'b0, 1'b0};
  int         rd_cnt [3] = '{0, 0, 0};
  int         rd_empty [3] = '{0, 0, 0};
  int         done_cnt [3] = '{0, 0, 0};

  // FWFT fifo models; the pop seen mid-cycle is applied on the following edge.
  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign empty_w[g] = (wp[g] == rp[g]);
    assign rdata_w[g] = mem[g][rp[g] % 16];
    always @(negedge clk) begin
      pop[g] = rd_w[g];
      if (rd_w[g] === 1'b1) rd_cnt[g] = rd_cnt[g] + 1;
      if (rd_w[g] === 1'b1 && empty_w[g]) rd_empty[g] = rd_empty[g] + 1;
      if (done_w[g] === 1'b1) done_cnt[g] = done_cnt[g] + 1;
    end
    always @(posedge clk) if (pop[g]) rp[g] <= rp[g] + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wp[i] % 16] = d;
    wp[i] = wp[i] + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent receiver: counts ticks from the start edge, samples each bit at
  // tick 8 of its 16, and times the start, data and stop segments in clks.
  task automatic rx_frame(input int i, input int nb, input int sbt,
                          output logic [8:0] bits, output int idle_wait,
                          output int start_clks, output int data_clks,
                          output int stop_clks, output logic line_ok, output logic done_ok);
    int tk, clks, data_end, total;
    bits = '0; idle_wait = 0; start_clks = 0; data_clks = 0; stop_clks = 0;
    line_ok = 1'b1; done_ok = 1'b0; tk = 0; clks = 0; data_end = 0;
    total = 16 * (1 + nb) + sbt;
    while (tx_w[i] !== 1'b0 && idle_wait < 20000) begin
      step();
      idle_wait++;
    end
    if (tx_w[i] !== 1'b0) begin
      idle_wait = -1;
      line_ok = 1'b0;
      return;
    end
    while (tk < total && clks < 20000) begin
      step();
      clks++;
      if (s_tick) begin
        tk++;
        if (tk == 16) start_clks = clks;
        if (tk == 16 * (1 + nb)) data_end = clks;
        if (tk % 16 == 8 && tk > 16 && tk < 16 * (1 + nb)) bits[(tk / 16) - 1] = tx_w[i];
      end
      if (tk < 16 && tx_w[i] !== 1'b0) line_ok = 1'b0;
      if (tk >= 16 * (1 + nb) && tx_w[i] !== 1'b1) line_ok = 1'b0;
      if (tk == total) done_ok = (done_w[i] === 1'b1);
      else if (done_w[i] === 1'b1) line_ok = 1'b0;
    end
    data_clks = data_end - start_clks;
    stop_clks = clks - data_end;
  endtask

  logic [8:0] bits;
  logic       line_ok, done_ok;
  int         iw, st, dc, sc, lows, busys, rd0, tk, guard;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_tx", tx_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_rd", rd_w[0], 0);
    chk("rst_tx_sb32", tx_w[2], 1);

    // Idle with empty fifo for 1000 clks
    reset = 1'b0;
    lows = 0; busys = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (tx_w[0] !== 1'b1) lows++;
      if (busy_w[0] !== 1'b0) busys++;
    end
    chk("idle_tx_low_clks", lows, 0);
    chk("idle_busy_clks", busys, 0);
    chk("idle_rd_cnt", rd_cnt[0], 0);

    // Single 0x55 frame
    push(0, 8'h55);
    rx_frame(0, 8, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("f55_data", bits, 9'h055);
    chk("f55_start_in_151_160", (st >= 151 && st <= 160), 1);
    chk("f55_data_clks", dc, 1280);
    chk("f55_stop_clks", sc, 160);
    chk("f55_line", line_ok, 1);
    chk("f55_done_at_stop_end", done_ok, 1);
    step();
    chk("f55_rd_cnt", rd_cnt[0], 1);
    chk("f55_done_cnt", done_cnt[0], 1);
    chk("f55_busy_after", busy_w[0], 0);

    // Back-to-back 0xA3, 0x0F, 0xFF
    push(0, 8'hA3); push(0, 8'h0F); push(0, 8'hFF);
    rx_frame(0, 8, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("b2b_a3_data", bits, 9'h0A3);
    chk("b2b_a3_done", done_ok, 1);
    rx_frame(0, 8, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("b2b_0f_data", bits, 9'h00F);
    chk("b2b_0f_idle_gap", iw, 1);
    chk("b2b_0f_line", line_ok, 1);
    rx_frame(0, 8, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("b2b_ff_data", bits, 9'h0FF);
    chk("b2b_ff_idle_gap", iw, 1);
    chk("b2b_ff_stop_clks", sc, 160);
    step();
    chk("b2b_rd_cnt", rd_cnt[0], 4);
    chk("b2b_fifo_empty", empty_w[0], 1);
    chk("b2b_done_cnt", done_cnt[0], 4);

    // Even parity on the PAR_EN transmitter
    push(1, 8'h07);
    rx_frame(1, 9, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("par_07_bits", bits, 9'h107);
    chk("par_07_done", done_ok, 1);
    push(1, 8'h03);
    rx_frame(1, 9, 16, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("par_03_bits", bits, 9'h003);
    chk("par_03_stop_clks", sc, 160);

    // Two stop bits
    push(2, 8'h81);
    rx_frame(2, 8, 32, bits, iw, st, dc, sc, line_ok, done_ok);
    chk("sb32_81_data", bits, 9'h081);
    chk("sb32_stop_clks", sc, 320);
    chk("sb32_line", line_ok, 1);
    chk("sb32_done", done_ok, 1);

    // Reset in the middle of data bit 4 of 0x3C
    push(0, 8'h3C);
    guard = 0;
    while (tx_w[0] !== 1'b0 && guard < 100) begin step(); guard++; end
    chk("rst_mid_start_seen", tx_w[0], 0);
    tk = 0; guard = 0;
    while (tk < 88 && guard < 2000) begin
      step();
      guard++;
      if (s_tick) tk++;
    end
    chk("rst_mid_bit4_level", tx_w[0], 1);
    chk("rst_mid_busy_before", busy_w[0], 1);
    rd0 = rd_cnt[0];
    reset = 1'b1;
    step();
    chk("rst_mid_tx", tx_w[0], 1);
    chk("rst_mid_busy", busy_w[0], 0);
    reset = 1'b0;
    lows = 0; busys = 0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (tx_w[0] !== 1'b1) lows++;
      if (busy_w[0] !== 1'b0) busys++;
    end
    chk("rst_after_tx_low_clks", lows, 0);
    chk("rst_after_busy_clks", busys, 0);
    chk("rst_after_rd_cnt", rd_cnt[0], rd0);

    chk("rd_while_empty_0", rd_empty[0], 0);
    chk("rd_while_empty_1", rd_empty[1], 0);
    chk("rd_while_empty_2", rd_empty[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
